// File: rtl/seq_det_pkg.sv
// Shared types, display codes and helpers for the multi-channel sequence detector.
package seq_det_pkg;

  localparam int PAT_MAX = 8;

  typedef logic [2:0] prog_t;

  localparam logic [7:0]        SEG_DASH  = 8'h40;
  localparam logic [0:7][6:0]   SEG_DIGIT = {7'h3F, 7'h06, 7'h5B, 7'h4F,
                                             7'h66, 7'h6D, 7'h7D, 7'h07};

  function automatic logic [6:0] seg_digit(input logic [2:0] ch);
    return SEG_DIGIT[ch];
  endfunction

  // A zero length still means "match one bit"; anything past the pattern register is clamped.
  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    if (l == 4'd0)           return 4'd1;
    if (l > 4'(PAT_MAX))     return 4'(PAT_MAX);
    return l;
  endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// Round-robin one-hot arbiter: first requester at or after rr wins, nothing when blocked.
module seq_det_rr_arb #(
  parameter int NCH = 4,
  parameter int RRW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [RRW-1:0] rr,
  input  logic           block,
  output logic [NCH-1:0] gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(rr) + i) % NCH;
      if (!found && !block && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// One pattern-match engine shared round-robin across NCH serial channels, with 7-seg readout.
// Optional per-channel saturating hit counters: define SEQ_DET_HIT_CNT_EN.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [NCH-1:0] in_valid,
  input  logic [NCH-1:0] in_bit,
  output logic [NCH-1:0] in_ready,
  input  logic           cfg_we,
  input  logic [7:0]     cfg_pat,
  input  logic [3:0]     cfg_len,
  output logic           hit_pulse,
  output logic [2:0]     hit_ch,
  output logic [7:0]     seg_out,
  output logic [7:0]     cnt_out,
  input  logic [2:0]     cnt_sel
);

  localparam int RRW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int HW  = $clog2(HOLD_CYCLES + 1);

  logic [7:0]     pat_q;
  logic [3:0]     len_q;
  prog_t          prog_q [NCH];
  logic [RRW-1:0] rr_q, rr_d;
  logic [HW-1:0]  hold_q;
  logic           hit_pulse_q;
  logic [2:0]     hit_ch_q;

  logic [NCH-1:0] gnt;
  logic           any_gnt, b, match, last, hit_d;
  logic [RRW-1:0] gidx;
  prog_t          p, prog_d;

  // Reset is active-high here; the arbiter is also held off while reset is asserted.
  seq_det_rr_arb #(.NCH(NCH), .RRW(RRW)) u_arb (
    .req   (in_valid),
    .rr    (rr_q),
    .block (rst_n | ~en | cfg_we),
    .gnt   (gnt)
  );

  always_comb begin
    gidx = '0;
    for (int c = 0; c < NCH; c++)
      if (gnt[c]) gidx = RRW'(c);
    any_gnt = |gnt;
    b       = in_bit[gidx];
    p       = prog_q[gidx];
    match   = (b == pat_q[p]);
    last    = ((4'(p) + 4'd1) == len_q);
    hit_d   = any_gnt & match & last;
    // Mismatch falls back only to the first pattern bit, never deeper.
    if (match) prog_d = last ? prog_t'(0) : p + prog_t'(1);
    else       prog_d = (b == pat_q[0]) ? prog_t'(1) : prog_t'(0);
    rr_d = (int'(gidx) == NCH - 1) ? '0 : gidx + RRW'(1);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pat_q       <= 8'h00;
      len_q       <= 4'd1;
      rr_q        <= '0;
      hold_q      <= '0;
      hit_pulse_q <= 1'b0;
      hit_ch_q    <= 3'd0;
      for (int c = 0; c < NCH; c++) prog_q[c] <= '0;
    end else if (cfg_we) begin
      pat_q       <= cfg_pat;
      len_q       <= clamp_len(cfg_len);
      hold_q      <= '0;
      hit_pulse_q <= 1'b0;
      for (int c = 0; c < NCH; c++) prog_q[c] <= '0;
    end else begin
      hit_pulse_q <= hit_d;
      if (any_gnt) begin
        prog_q[gidx] <= prog_d;
        rr_q         <= rr_d;
      end
      if (hit_d) begin
        hit_ch_q <= 3'(gidx);
        hold_q   <= HW'(HOLD_CYCLES);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HW'(1);
      end
    end
  end

  assign in_ready  = gnt;
  assign hit_pulse = hit_pulse_q;
  assign hit_ch    = hit_ch_q;
  assign seg_out   = (hold_q != '0) ? {1'b1, seg_digit(hit_ch_q)} : SEG_DASH;

`ifdef SEQ_DET_HIT_CNT_EN
  logic [7:0] cnt_q [NCH];
  logic [7:0] cnt_out_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_out_q <= 8'h00;
      for (int c = 0; c < NCH; c++) cnt_q[c] <= 8'h00;
    end else begin
      cnt_out_q <= (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel[RRW-1:0]] : 8'h00;
      if (cfg_we) begin
        for (int c = 0; c < NCH; c++) cnt_q[c] <= 8'h00;
      end else if (hit_d && cnt_q[gidx] != 8'hFF) begin
        cnt_q[gidx] <= cnt_q[gidx] + 8'd1;
      end
    end
  end

  assign cnt_out = cnt_out_q;
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = 8'h00;
`endif

endmodule
